demux_frame: RTL and testbench

- Sequential 1-to-4 demultiplexer. It is the receive-side counterpart of the team's 4:1 select mux.
- A stream of WIDTH-bit words arrives on one input lane with a valid qualifier. Each word is routed into one of four registered output lanes.
- Lane choice is either automatic (round-robin slot counter, frame-based) or explicit (2-bit select s1,s0).
- Sits in the lab datapath wherever a muxed or serialized bus must be fanned back out to four destinations.

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_frame_if.sv | 32 +++
 rtl/demux_slot_ctr.sv | 42 ++++
 rtl/demux_frame.sv | 103 ++++++++++
 tb/tb_demux_frame.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the frame demultiplexer.
package demux_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t SLOT_LAST = slot_t'(LANES - 1);

    localparam logic MODE_AUTO = 1'b0;
    localparam logic MODE_SEL  = 1'b1;

endpackage

// File: rtl/demux_frame_if.sv
// Input lane, control and fanned-out output lanes of the frame demultiplexer.
interface demux_frame_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
);
    import demux_pkg::*;

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sel_mode;
    logic             s1;
    logic             s0;
    logic             clear;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic             frame_valid;
    slot_t            slot;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output din, din_valid, sel_mode, s1, s0, clear,
        input  d0, d1, d2, d3, frame_valid, slot, frame_cnt
    );

    modport slave (
        input  din, din_valid, sel_mode, s1, s0, clear,
        output d0, d1, d2, d3, frame_valid, slot, frame_cnt
    );

endinterface

// File: rtl/demux_slot_ctr.sv
// Wrapping 2-bit slot counter with abort and a terminal-count strobe.
module demux_slot_ctr
    import demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  abort,
    input  logic  advance,
    output slot_t slot,
    output logic  tc_c
);

    slot_t slot_q;
    slot_t slot_d;

    // Next slot: abort returns to 0, advance steps and wraps after the last slot.
    always_comb begin
        slot_d = slot_q;
        if (abort) begin
            slot_d = '0;
        end else if (advance) begin
            slot_d = slot_q + slot_t'(1);
        end
    end

    // Terminal count: last slot being filled this cycle.
    always_comb begin
        tc_c = advance && !abort && (slot_q == SLOT_LAST);
    end

    // Slot register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/demux_frame.sv
// 1-to-4 demultiplexer: round-robin framed or explicitly selected lane routing.
module demux_frame
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    demux_frame_if.slave bus
);

    logic [LANES-1:0][WIDTH-1:0] lane_q;
    logic [LANES-1:0][WIDTH-1:0] lane_d;
    logic [LANES-2:0][WIDTH-1:0] shadow_q;
    logic [LANES-2:0][WIDTH-1:0] shadow_d;
    logic                        frame_valid_q;
    logic                        frame_valid_d;
    logic [CNT_W-1:0]            frame_cnt_q;
    logic [CNT_W-1:0]            frame_cnt_d;
    logic [LANES-1:0]            lane_we;
    logic                        advance;
    logic                        abort;
    logic                        frame_done_c;
    slot_t                       slot;

    // Auto-mode slot stepping; clear or explicit mode discards any partial frame.
    always_comb begin
        advance = bus.din_valid && !bus.clear && (bus.sel_mode == MODE_AUTO);
        abort   = bus.clear || (bus.sel_mode == MODE_SEL);
    end

    demux_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort   (abort),
        .advance (advance),
        .slot    (slot),
        .tc_c    (frame_done_c)
    );

    // Explicit-select lane write-enable decode.
    always_comb begin
        lane_we = '0;
        case ({bus.s1, bus.s0})
            2'b00:   lane_we[0] = 1'b1;
            2'b01:   lane_we[1] = 1'b1;
            2'b10:   lane_we[2] = 1'b1;
            default: lane_we[3] = 1'b1;
        endcase
    end

    // Next-state for lanes, shadow words, frame pulse and frame counter.
    always_comb begin
        lane_d        = lane_q;
        shadow_d      = shadow_q;
        frame_valid_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        if (!bus.clear && bus.din_valid) begin
            if (bus.sel_mode == MODE_SEL) begin
                if (lane_we[0]) lane_d[0] = bus.din;
                if (lane_we[1]) lane_d[1] = bus.din;
                if (lane_we[2]) lane_d[2] = bus.din;
                if (lane_we[3]) lane_d[3] = bus.din;
            end else if (frame_done_c) begin
                lane_d        = {bus.din, shadow_q};
                frame_valid_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + CNT_W'(1);
            end else begin
                case (slot)
                    2'd0:    shadow_d[0] = bus.din;
                    2'd1:    shadow_d[1] = bus.din;
                    2'd2:    shadow_d[2] = bus.din;
                    default: ;
                endcase
            end
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q        <= '0;
            shadow_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            lane_q        <= lane_d;
            shadow_q      <= shadow_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign bus.d0          = lane_q[0];
    assign bus.d1          = lane_q[1];
    assign bus.d2          = lane_q[2];
    assign bus.d3          = lane_q[3];
    assign bus.frame_valid = frame_valid_q;
    assign bus.slot        = slot;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_demux_frame.sv
// Directed self-checking bench for demux_frame (WIDTH=4, CNT_W=2).
module tb_demux_frame;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    demux_frame_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux_frame #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3);
        chk({tag, ".d0"}, 32'(bus.d0), 32'(e0));
        chk({tag, ".d1"}, 32'(bus.d1), 32'(e1));
        chk({tag, ".d2"}, 32'(bus.d2), 32'(e2));
        chk({tag, ".d3"}, 32'(bus.d3), 32'(e3));
    endtask

    task automatic step(input logic [3:0] din, input logic v, input logic mode,
                        input logic [1:0] s, input logic clr);
        bus.din       = din;
        bus.din_valid = v;
        bus.sel_mode  = mode;
        bus.s1        = s[1];
        bus.s0        = s[0];
        bus.clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic auto_word(input logic [3:0] din);
        step(din, 1'b1, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(4'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.din = '0; bus.din_valid = 1'b0; bus.sel_mode = 1'b0;
        bus.s1 = 1'b0; bus.s0 = 1'b0; bus.clear = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        chk_lanes("rst", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst.fv", 32'(bus.frame_valid), 32'd0);
        chk("rst.slot", 32'(bus.slot), 32'd0);
        chk("rst.cnt", 32'(bus.frame_cnt), 32'd0);

        // Auto frame 1,0,1,1
        auto_word(4'h1);
        auto_word(4'h0);
        auto_word(4'h1);
        chk("a1.slot3", 32'(bus.slot), 32'd3);
        chk("a1.fv_early", 32'(bus.frame_valid), 32'd0);
        chk_lanes("a1.hold", 4'h0, 4'h0, 4'h0, 4'h0);
        auto_word(4'h1);
        chk_lanes("a1", 4'h1, 4'h0, 4'h1, 4'h1);
        chk("a1.fv", 32'(bus.frame_valid), 32'd1);
        chk("a1.cnt", 32'(bus.frame_cnt), 32'd1);
        chk("a1.slot", 32'(bus.slot), 32'd0);
        step(4'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("a1.fv_off", 32'(bus.frame_valid), 32'd0);

        // Partial frame aborted by clear (with a valid word dropped)
        auto_word(4'h5);
        auto_word(4'h6);
        auto_word(4'h7);
        step(4'hF, 1'b1, 1'b0, 2'b00, 1'b1);
        chk("clr.slot", 32'(bus.slot), 32'd0);
        chk("clr.cnt", 32'(bus.frame_cnt), 32'd1);
        chk_lanes("clr.hold", 4'h1, 4'h0, 4'h1, 4'h1);
        auto_word(4'hA);
        step(4'h3, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("gap.slot", 32'(bus.slot), 32'd1);
        auto_word(4'hB);
        auto_word(4'hC);
        auto_word(4'hD);
        chk_lanes("clr.frame", 4'hA, 4'hB, 4'hC, 4'hD);
        chk("clr.fv", 32'(bus.frame_valid), 32'd1);
        chk("clr.cnt2", 32'(bus.frame_cnt), 32'd2);

        // Explicit select; one pending auto word is discarded
        auto_word(4'h4);
        chk("sel.pre_slot", 32'(bus.slot), 32'd1);
        step(4'h1, 1'b1, 1'b1, 2'b10, 1'b0);
        chk_lanes("sel10", 4'hA, 4'hB, 4'h1, 4'hD);
        chk("sel.fv", 32'(bus.frame_valid), 32'd0);
        chk("sel.slot", 32'(bus.slot), 32'd0);
        step(4'h9, 1'b1, 1'b1, 2'b11, 1'b0);
        chk_lanes("sel11", 4'hA, 4'hB, 4'h1, 4'h9);
        step(4'hE, 1'b1, 1'b1, 2'b00, 1'b1);
        chk_lanes("sel.clr", 4'hA, 4'hB, 4'h1, 4'h9);
        step(4'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("sel.back_slot", 32'(bus.slot), 32'd0);
        chk("sel.cnt", 32'(bus.frame_cnt), 32'd2);

        // Continuous 12-word stream: pulses after words 4, 8, 12; counter wraps 3 -> 0 -> 1
        for (int i = 1; i <= 12; i++) begin
            auto_word(4'(i));
            chk($sformatf("stream.fv%0d", i), 32'(bus.frame_valid), (i % 4 == 0) ? 32'd1 : 32'd0);
            if (i == 4)  chk("stream.cnt4", 32'(bus.frame_cnt), 32'd3);
            if (i == 8)  chk("stream.cnt8", 32'(bus.frame_cnt), 32'd0);
            if (i == 12) chk("stream.cnt12", 32'(bus.frame_cnt), 32'd1);
        end
        chk_lanes("stream", 4'h9, 4'hA, 4'hB, 4'hC);

        // Reset mid-frame, then a fresh frame
        auto_word(4'h7);
        auto_word(4'h8);
        do_reset();
        chk_lanes("rst2", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst2.slot", 32'(bus.slot), 32'd0);
        chk("rst2.cnt", 32'(bus.frame_cnt), 32'd0);
        auto_word(4'h3);
        auto_word(4'h4);
        auto_word(4'h5);
        auto_word(4'h6);
        chk_lanes("fresh", 4'h3, 4'h4, 4'h5, 4'h6);
        chk("fresh.fv", 32'(bus.frame_valid), 32'd1);
        chk("fresh.cnt", 32'(bus.frame_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
